reg_access_ctrl: RTL and testbench

//  Command-side initiator for the 8-bit register file. Parses command bytes from the

---
 rtl/reg_access_ctrl_pkg.sv | 19 +
 rtl/reg_access_ctrl.sv | 131 +++++++++++++
 tb/tb_reg_access_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/reg_access_ctrl_pkg.sv
// Shared definitions for the register-access command controller:
// command opcodes and the controller state encoding.
package reg_access_ctrl_pkg;

    localparam logic [7:0] WR_CMD = 8'hAA;
    localparam logic [7:0] RD_CMD = 8'hBB;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_ISSUE,
        RD_ADDR,
        RD_ISSUE,
        RD_WAIT,
        TX_SEND
    } state_t;

endpackage

// File: rtl/reg_access_ctrl.sv
// Command-side initiator for the register file: parses UART command frames,
// issues single-cycle RegFile writes/reads and forwards read data to the TX path.
module reg_access_ctrl
    import reg_access_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ADDR       = 4,
    parameter int RD_TIMEOUT = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] RX_P_DATA,
    input  logic             RX_D_VLD,
    input  logic [WIDTH-1:0] RdData,
    input  logic             RdData_VLD,
    input  logic             TX_Busy,
    output logic             WrEn,
    output logic             RdEn,
    output logic [ADDR-1:0]  Address,
    output logic [WIDTH-1:0] WrData,
    output logic [WIDTH-1:0] TX_P_DATA,
    output logic             TX_D_VLD,
    output logic             RD_ERR
);

    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             wr_en_nxt, rd_en_nxt, tx_vld_nxt, rd_err_nxt;
    logic [ADDR-1:0]  addr_nxt;
    logic [WIDTH-1:0] wr_data_nxt, tx_data_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            Address   <= '0;
            WrData    <= '0;
            TX_P_DATA <= '0;
            TX_D_VLD  <= 1'b0;
            RD_ERR    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            WrEn      <= wr_en_nxt;
            RdEn      <= rd_en_nxt;
            Address   <= addr_nxt;
            WrData    <= wr_data_nxt;
            TX_P_DATA <= tx_data_nxt;
            TX_D_VLD  <= tx_vld_nxt;
            RD_ERR    <= rd_err_nxt;
        end
    end

    // Strobes are computed from the transition into the issuing state, so the
    // registered WrEn/RdEn are high exactly while the FSM sits in WR_ISSUE/RD_ISSUE.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_nxt   = state;
        cnt_nxt     = cnt;
        wr_en_nxt   = 1'b0;
        rd_en_nxt   = 1'b0;
        tx_vld_nxt  = 1'b0;
        rd_err_nxt  = RD_ERR;
        addr_nxt    = Address;
        wr_data_nxt = WrData;
        tx_data_nxt = TX_P_DATA;

        unique case (state)
            IDLE: begin
                if (RX_D_VLD && RX_P_DATA == WIDTH'(WR_CMD)) begin
                    state_nxt  = WR_ADDR;
                    rd_err_nxt = 1'b0;
                end else if (RX_D_VLD && RX_P_DATA == WIDTH'(RD_CMD)) begin
                    state_nxt  = RD_ADDR;
                    rd_err_nxt = 1'b0;
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_nxt  = RX_P_DATA[ADDR-1:0];
                    state_nxt = WR_DATA;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_data_nxt = RX_P_DATA;
                    wr_en_nxt   = 1'b1;
                    state_nxt   = WR_ISSUE;
                end
            end
            WR_ISSUE: state_nxt = IDLE;
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    addr_nxt  = RX_P_DATA[ADDR-1:0];
                    rd_en_nxt = 1'b1;
                    state_nxt = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (RdData_VLD) begin
                    tx_data_nxt = RdData;
                    state_nxt   = TX_SEND;
                end else if (cnt == CNT_LAST) begin
                    rd_err_nxt = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            TX_SEND: begin
                if (!TX_Busy) begin
                    tx_vld_nxt = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed self-checking bench for reg_access_ctrl: write, read, TX backpressure,
// read timeout, garbage/address wrap and mid-frame reset.
module tb_reg_access_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    logic [7:0] RdData;
    logic       RdData_VLD;
    logic       TX_Busy;
    logic       WrEn, RdEn, TX_D_VLD, RD_ERR;
    logic [3:0] Address;
    logic [7:0] WrData, TX_P_DATA;

    int tests_run    = 0;
    int tests_failed = 0;
    int wr_pulses    = 0;
    int rd_pulses    = 0;
    int tx_pulses    = 0;
    int both_high    = 0;

    reg_access_ctrl #(.WIDTH(8), .ADDR(4), .RD_TIMEOUT(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_P_DATA  (RX_P_DATA),
        .RX_D_VLD   (RX_D_VLD),
        .RdData     (RdData),
        .RdData_VLD (RdData_VLD),
        .TX_Busy    (TX_Busy),
        .WrEn       (WrEn),
        .RdEn       (RdEn),
        .Address    (Address),
        .WrData     (WrData),
        .TX_P_DATA  (TX_P_DATA),
        .TX_D_VLD   (TX_D_VLD),
        .RD_ERR     (RD_ERR)
    );

    always #5 CLK = ~CLK;

    // Pulse counters; deltas are only read at least one negedge after the last pulse.
    always @(negedge CLK) begin
        if (!RST) begin
            if (WrEn)         wr_pulses++;
            if (RdEn)         rd_pulses++;
            if (TX_D_VLD)     tx_pulses++;
            if (WrEn && RdEn) both_high++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one byte for one cycle; returns on the negedge after it was sampled.
    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    // Drives RdData_VLD for one cycle, starting one cycle after the RdEn pulse was seen.
    task automatic return_read(input logic [7:0] d);
        @(negedge CLK);
        RdData     = d;
        RdData_VLD = 1'b1;
        @(negedge CLK);
        RdData_VLD = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0, r0, t0, k;
        logic seen;

        RST = 1'b1; RX_P_DATA = '0; RX_D_VLD = 1'b0;
        RdData = '0; RdData_VLD = 1'b0; TX_Busy = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset_outputs", {WrEn, RdEn, TX_D_VLD, RD_ERR}, 4'b0000);
        check("reset_addr_data", {Address, WrData, TX_P_DATA}, 20'h0);
        RST = 1'b0;

        // Write AA,05,3C: WrEn rises the cycle after the data strobe.
        w0 = wr_pulses;
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        check("wr_en_high", WrEn, 1'b1);
        check("wr_addr", Address, 4'h5);
        check("wr_data", WrData, 8'h3C);
        check("wr_no_rden", RdEn, 1'b0);
        @(negedge CLK);
        check("wr_en_low", WrEn, 1'b0);
        check("wr_one_pulse", wr_pulses - w0, 1);

        // Read BB,05 returning the value written above.
        r0 = rd_pulses; t0 = tx_pulses;
        send_byte(8'hBB); send_byte(8'h05);
        check("rd_en_high", RdEn, 1'b1);
        check("rd_addr", Address, 4'h5);
        return_read(8'h3C);
        check("rd_en_low", RdEn, 1'b0);
        check("tx_not_yet", TX_D_VLD, 1'b0);
        @(negedge CLK);
        check("tx_vld", TX_D_VLD, 1'b1);
        check("tx_data", TX_P_DATA, 8'h3C);
        @(negedge CLK);
        check("tx_vld_low", TX_D_VLD, 1'b0);
        check("tx_data_held", TX_P_DATA, 8'h3C);
        check("rd_one_pulse", rd_pulses - r0, 1);
        check("tx_one_pulse", tx_pulses - t0, 1);

        // Backpressure: TX held busy, an AA arriving in TX_SEND must be dropped.
        t0 = tx_pulses; w0 = wr_pulses;
        TX_Busy = 1'b1;
        send_byte(8'hBB); send_byte(8'h09);
        return_read(8'h5A);
        send_byte(8'hAA);
        repeat (10) @(negedge CLK);
        check("tx_held_busy", tx_pulses - t0, 0);
        TX_Busy = 1'b0;
        seen = 1'b0; k = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge CLK);
            if (TX_D_VLD) begin seen = 1'b1; k = i; break; end
        end
        check("tx_after_release", seen, 1'b1);
        check("tx_release_latency", k, 1);
        check("tx_bp_data", TX_P_DATA, 8'h5A);
        repeat (3) @(negedge CLK);
        check("tx_bp_once", tx_pulses - t0, 1);
        send_byte(8'h06); send_byte(8'h77);
        @(negedge CLK);
        check("dropped_aa_no_write", wr_pulses - w0, 0);

        // Timeout: one RdEn cycle then eight wait cycles, then RD_ERR.
        t0 = tx_pulses;
        send_byte(8'hBB); send_byte(8'h02);
        check("to_rd_en", RdEn, 1'b1);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (RD_ERR) begin k = i; break; end
        end
        check("to_rd_err_latency", k, 9);
        @(negedge CLK);
        check("to_no_tx", tx_pulses - t0, 0);

        // Garbage then write with wrapped address; AA clears RD_ERR.
        w0 = wr_pulses;
        send_byte(8'h11);
        check("garbage_keeps_err", RD_ERR, 1'b1);
        send_byte(8'hAA);
        check("opcode_clears_err", RD_ERR, 1'b0);
        send_byte(8'hF7); send_byte(8'h01);
        check("wrap_wr_en", WrEn, 1'b1);
        check("wrap_addr", Address, 4'h7);
        check("wrap_data", WrData, 8'h01);
        @(negedge CLK);
        check("wrap_one_pulse", wr_pulses - w0, 1);

        // Reset mid-frame discards the pending write.
        send_byte(8'hAA); send_byte(8'h03);
        #2 RST = 1'b1;
        #1 check("rst_async_addr", Address, 4'h0);
        check("rst_async_strobes", {WrEn, RdEn, TX_D_VLD}, 3'b000);
        @(negedge CLK);
        RST = 1'b0;
        w0 = wr_pulses; r0 = rd_pulses; t0 = tx_pulses;
        send_byte(8'h44);
        repeat (2) @(negedge CLK);
        check("rst_no_write", wr_pulses - w0, 0);
        send_byte(8'hBB); send_byte(8'h03);
        check("post_rst_rd_en", RdEn, 1'b1);
        check("post_rst_addr", Address, 4'h3);
        return_read(8'h77);
        @(negedge CLK);
        check("post_rst_tx", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h77});
        @(negedge CLK);
        check("post_rst_counts", {rd_pulses - r0, tx_pulses - t0}, {32'd1, 32'd1});
        check("never_both_en", both_high, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
